// File: rtl/imem_loader.sv
// imem_loader: receives a program image as a byte stream and writes it into
// instruction memory. The stream is a 16-bit big-endian word count followed by
// that many big-endian 32-bit words. The CPU is held in reset until the image
// has been completely written.
module imem_loader #(
  parameter int ADDR_W    = 8,
  parameter int DEPTH     = 256,
  parameter int BASE_ADDR = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done,
  output logic              error
);

  typedef enum logic [2:0] {
    IDLE,
    HDR0,
    HDR1,
    DATA,
    WRITE,
    DONE,
    ERROR
  } state_t;

  localparam logic [ADDR_W-1:0] BASE    = ADDR_W'(BASE_ADDR);
  localparam logic [16:0]       DEPTH_L = 17'(DEPTH);

  state_t      state_reg;
  logic [7:0]  count_hi_reg;
  logic [15:0] words_left_reg;
  logic [1:0]  byte_idx_reg;
  logic [23:0] shift_reg;

  logic        accept;
  logic [15:0] hdr_count;

  // A byte transfers only while the registered in_ready is high.
  assign accept    = in_valid && in_ready;
  // Full header count as it becomes known on the second header byte.
  assign hdr_count = {count_hi_reg, in_data};

  // Load sequencer; every output is registered and updated with the state.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg      <= IDLE;
      count_hi_reg   <= '0;
      words_left_reg <= '0;
      byte_idx_reg   <= '0;
      shift_reg      <= '0;
      in_ready       <= 1'b0;
      imem_we        <= 1'b0;
      imem_addr      <= BASE;
      imem_wdata     <= '0;
      cpu_reset      <= 1'b1;
      busy           <= 1'b0;
      done           <= 1'b0;
      error          <= 1'b0;
    end else begin
      // The write strobe is a single-cycle pulse raised only from DATA.
      imem_we <= 1'b0;
      case (state_reg)
        IDLE, DONE, ERROR: begin
          if (start) begin
            state_reg    <= HDR0;
            in_ready     <= 1'b1;
            busy         <= 1'b1;
            cpu_reset    <= 1'b1;
            done         <= 1'b0;
            error        <= 1'b0;
            byte_idx_reg <= '0;
          end
        end
        HDR0: begin
          if (accept) begin
            count_hi_reg <= in_data;
            state_reg    <= HDR1;
          end
        end
        HDR1: begin
          if (accept) begin
            if (hdr_count == 16'd0) begin
              // Empty image: nothing to write, release the CPU at once.
              state_reg <= DONE;
              in_ready  <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
              cpu_reset <= 1'b0;
            end else if ({1'b0, hdr_count} > DEPTH_L) begin
              // Image cannot fit; keep the CPU in reset.
              state_reg <= ERROR;
              in_ready  <= 1'b0;
              busy      <= 1'b0;
              error     <= 1'b1;
            end else begin
              state_reg      <= DATA;
              words_left_reg <= hdr_count;
              imem_addr      <= BASE;
              byte_idx_reg   <= '0;
            end
          end
        end
        DATA: begin
          if (accept) begin
            if (byte_idx_reg == 2'd3) begin
              // Fourth byte completes the word; stall input during the write.
              imem_wdata   <= {shift_reg, in_data};
              imem_we      <= 1'b1;
              in_ready     <= 1'b0;
              byte_idx_reg <= '0;
              state_reg    <= WRITE;
            end else begin
              shift_reg    <= {shift_reg[15:0], in_data};
              byte_idx_reg <= byte_idx_reg + 2'd1;
            end
          end
        end
        WRITE: begin
          imem_addr      <= imem_addr + 1'b1;
          words_left_reg <= words_left_reg - 16'd1;
          if (words_left_reg == 16'd1) begin
            state_reg <= DONE;
            in_ready  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
            cpu_reset <= 1'b0;
          end else begin
            state_reg <= DATA;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state_reg <= IDLE;
          in_ready  <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b0;
          error     <= 1'b0;
          cpu_reset <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Testbench for imem_loader: expected memory writes are queued as each image
// is driven and popped by a monitor that watches the write strobe.
module tb_imem_loader;

  localparam int ADDR_W    = 8;
  localparam int DEPTH     = 256;
  localparam int BASE_ADDR = 0;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic              in_valid = 1'b0;
  logic [7:0]        in_data = '0;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_reset;
  logic              busy;
  logic              done;
  logic              error;

  int err_cnt = 0;
  int chk_cnt = 0;
  int we_cnt  = 0;

  logic [31:0] img_words[$];
  logic [63:0] sb[$];
  logic        prev_we = 1'b0;

  imem_loader #(
    .ADDR_W(ADDR_W),
    .DEPTH(DEPTH),
    .BASE_ADDR(BASE_ADDR)
  ) dut (
    .clock(clock),
    .reset(reset),
    .start(start),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_ready(in_ready),
    .imem_we(imem_we),
    .imem_addr(imem_addr),
    .imem_wdata(imem_wdata),
    .cpu_reset(cpu_reset),
    .busy(busy),
    .done(done),
    .error(error)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Write monitor: one line per observed write, compared against the queue.
  always @(negedge clock) begin
    if (!reset && imem_we) begin
      we_cnt++;
      check("we_single_cycle", {63'd0, prev_we}, 64'd0);
      check("ready_low_in_write", {63'd0, in_ready}, 64'd0);
      if (sb.size() == 0) begin
        check("unexpected_write", 64'd1, 64'd0);
      end else begin
        logic [63:0] e;
        e = sb.pop_front();
        $display("write addr=%0h data=%08h (expected addr=%0h data=%08h)",
                 imem_addr, imem_wdata, e[32 +: ADDR_W], e[31:0]);
        check("write_addr", 64'(imem_addr), {{(64-ADDR_W){1'b0}}, e[32 +: ADDR_W]});
        check("write_data", 64'(imem_wdata), {32'd0, e[31:0]});
      end
    end
    prev_we = imem_we;
  end

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int n;
    if (gaps) begin
      n = $urandom_range(0, 2);
      repeat (n) begin
        in_valid = 1'b0;
        @(negedge clock);
      end
    end
    in_valid = 1'b1;
    in_data  = b;
    for (int i = 0; i < 50 && !in_ready; i++) @(negedge clock);
    if (!in_ready) check("byte_timeout", 64'(in_ready), 64'd1);
    @(posedge clock);
    @(negedge clock);
  endtask

  // Drives header + img_words and queues the expected writes.
  task automatic load_image(input bit gaps, input bit poke_start);
    logic [15:0] n;
    n = 16'(img_words.size());
    for (int i = 0; i < img_words.size(); i++)
      sb.push_back({24'd0, 8'(BASE_ADDR + i), img_words[i]});
    send_byte(n[15:8], gaps);
    send_byte(n[7:0], gaps);
    for (int i = 0; i < img_words.size(); i++) begin
      logic [31:0] w;
      w = img_words[i];
      if (poke_start && i == 1) begin
        in_valid = 1'b0;
        pulse_start();
      end
      for (int j = 3; j >= 0; j--) send_byte(w[j*8 +: 8], gaps);
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_end();
    int i;
    for (i = 0; i < 200 && !done && !error; i++) @(negedge clock);
    if (!done && !error) check("end_timeout", 64'd0, 64'd1);
  endtask

  task automatic set_prog();
    img_words.delete();
    img_words.push_back(32'h20080005);
    img_words.push_back(32'h8C090004);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_cpu_reset"}, 64'(cpu_reset), 64'd1);
    check({tag, "_in_ready"}, 64'(in_ready), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_error"}, 64'(error), 64'd0);
  endtask

  initial begin
    int base_we;

    // Test 1: reset state
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    check_idle_outputs("rst");
    check("rst_we", 64'(imem_we), 64'd0);
    check("rst_addr", 64'(imem_addr), 64'(BASE_ADDR));
    check("rst_wdata", 64'(imem_wdata), 64'd0);

    // Test 2: two-word image, latency of write and done
    set_prog();
    pulse_start();
    check("t2_busy", 64'(busy), 64'd1);
    check("t2_ready", 64'(in_ready), 64'd1);
    check("t2_cpu_reset", 64'(cpu_reset), 64'd1);
    load_image(1'b0, 1'b0);
    check("t2_we_after_last", 64'(imem_we), 64'd1);
    @(negedge clock);
    check("t2_done", 64'(done), 64'd1);
    check("t2_cpu_rel", 64'(cpu_reset), 64'd0);
    check("t2_busy_end", 64'(busy), 64'd0);
    check("t2_sb_empty", 64'(sb.size()), 64'd0);

    // Test 3: random gaps, with start poked mid-load (must be ignored)
    for (int r = 0; r < 3; r++) begin
      img_words.delete();
      for (int i = 0; i < 4; i++) img_words.push_back($urandom);
      pulse_start();
      check("t3_done_clear", 64'(done), 64'd0);
      load_image(1'b1, 1'b1);
      wait_end();
      check("t3_done", 64'(done), 64'd1);
      check("t3_sb_empty", 64'(sb.size()), 64'd0);
    end

    // Test 4: empty image
    base_we = we_cnt;
    pulse_start();
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    in_valid = 1'b0;
    check("t4_done", 64'(done), 64'd1);
    check("t4_cpu_rel", 64'(cpu_reset), 64'd0);
    check("t4_no_writes", 64'(we_cnt - base_we), 64'd0);

    // Test 5: N=257 > DEPTH -> error, then a normal load
    base_we = we_cnt;
    pulse_start();
    send_byte(8'h01, 1'b0);
    send_byte(8'h01, 1'b0);
    in_valid = 1'b0;
    check("t5_error", 64'(error), 64'd1);
    check("t5_cpu_reset", 64'(cpu_reset), 64'd1);
    check("t5_busy", 64'(busy), 64'd0);
    check("t5_ready", 64'(in_ready), 64'd0);
    repeat (3) @(negedge clock);
    check("t5_no_writes", 64'(we_cnt - base_we), 64'd0);
    set_prog();
    pulse_start();
    check("t5_error_clear", 64'(error), 64'd0);
    load_image(1'b1, 1'b0);
    wait_end();
    check("t5_reload_done", 64'(done), 64'd1);
    check("t5_sb_empty", 64'(sb.size()), 64'd0);

    // Boundary: N == DEPTH is accepted, fills every word
    img_words.delete();
    for (int i = 0; i < DEPTH; i++) img_words.push_back($urandom);
    pulse_start();
    load_image(1'b0, 1'b0);
    wait_end();
    check("full_done", 64'(done), 64'd1);
    check("full_error", 64'(error), 64'd0);
    check("full_sb_empty", 64'(sb.size()), 64'd0);

    // Test 6: reset after 5 bytes discards the partial load
    base_we = we_cnt;
    pulse_start();
    send_byte(8'h00, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'h20, 1'b0);
    send_byte(8'h08, 1'b0);
    send_byte(8'h00, 1'b0);
    in_valid = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check_idle_outputs("t6");
    repeat (3) @(negedge clock);
    check("t6_no_writes", 64'(we_cnt - base_we), 64'd0);
    set_prog();
    pulse_start();
    load_image(1'b0, 1'b0);
    wait_end();
    check("t6_done", 64'(done), 64'd1);
    check("t6_sb_empty", 64'(sb.size()), 64'd0);

    // Reset and start in the same cycle: reset wins
    reset = 1'b1;
    start = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    start = 1'b0;
    check_idle_outputs("rst_start");

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
